vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Produces VGA raster timing for the display path: hsync, vsync, video_on and the current pixel coordinates pixel_x/pixel_y.
- pixel_gen, the bitmap modules and player consume pixel_x/pixel_y/video_on from this block.
- Runs directly on the pixel clock clk_d, one pixel per cycle.
- Defaults give 640x480 @ 60 Hz: 800 clocks per line, 525 lines per frame, 25 MHz clk_d.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_DISPLAY, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk_d  input  1  pixel clock
- reset  input  1  asynchronous, active-high reset
- hsync  output  1  horizontal sync, registered
- vsync  output  1  vertical sync, registered
- video_on  output  1  high while (pixel_x, pixel_y) is inside the visible area
- pixel_x  output  10  current column, 0..H_TOTAL-1
- pixel_y  output  10  current row, 0..V_TOTAL-1
- line_start  output  1  one-cycle pulse when pixel_x==0
- frame_start  output  1  one-cycle pulse when pixel_x==0 and pixel_y==0

Behaviour:
- Derived totals: H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP; V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP. Both must be <= 1024 to fit the 10-bit outputs.
- Interface: one clock; reset is asynchronous and active-high.
- Every output is a flop. All outputs describe the same pixel in the same cycle; there is zero skew between coordinates and decodes. The implementation therefore decodes from the next-count values, not from the current outputs.
- Horizontal counter: increments every clk_d cycle. At H_TOTAL-1 it wraps to 0.
- Vertical counter: increments only in the cycle where the horizontal counter wraps. When it wraps from V_TOTAL-1 to 0 together with the horizontal counter, the frame ends.
- hsync = SYNC_ACTIVE while H_DISPLAY+H_FP <= pixel_x <= H_DISPLAY+H_FP+H_SYNC-1; otherwise ~SYNC_ACTIVE.
- vsync = SYNC_ACTIVE while V_DISPLAY+V_FP <= pixel_y <= V_DISPLAY+V_FP+V_SYNC-1; otherwise ~SYNC_ACTIVE. vsync changes only at a pixel_x==0 boundary.
- video_on = (pixel_x < H_DISPLAY) && (pixel_y < V_DISPLAY).
- line_start = (pixel_x == 0); frame_start = (pixel_x == 0 && pixel_y == 0).
- Reset (async assert, any cycle, including mid-line or mid-frame): pixel_x=0, pixel_y=0, hsync=~SYNC_ACTIVE, vsync=~SYNC_ACTIVE, video_on=1, line_start=1, frame_start=1. These are the values for pixel (0,0).
- First clk_d edge after reset release: pixel_x=1, pixel_y=0, line_start=0, frame_start=0.
- No illegal states: any counter value >= its total (reachable only through an upset) wraps to 0 on the next increment.
- Steady-state periods: exactly H_TOTAL*V_TOTAL cycles between frame_start pulses (420000 at defaults); H_TOTAL cycles between line_start pulses.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined: adds output frame_count [7:0]. It resets to 0 and increments by 1 (mod 256) in the same cycle frame_start rises, except for the reset-forced frame_start, which does not increment it. Intended to drive light_FSM timing and sprite animation.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Release reset, count cycles -> pixel_x steps 0..799 then returns to 0; pixel_y increments to 1 on that same edge; line_start high exactly when pixel_x==0.
- Observe hsync during line 0 -> low for pixel_x 656..751 (96 cycles), high elsewhere; video_on low from pixel_x=640 through 799.
- Run one full frame -> vsync low for pixel_y 490..491 (1600 cycles); video_on low for all pixel_y >= 480; next frame_start 420000 cycles after the first.
- Assert reset asynchronously at pixel_x=300, pixel_y=200, mid-cycle -> outputs go to (0,0) with hsync=vsync=1 and video_on=1 before the next clk_d edge; after release, timing restarts from (0,0).
- Rebuild with SYNC_ACTIVE=1 -> hsync/vsync polarity inverts; pixel_x, pixel_y and video_on are unchanged cycle-for-cycle.
- With VGA_FRAME_COUNT_EN defined, run 257 frames -> frame_count reads 0x01 after the 257th non-reset frame_start (256 increments wrap to 0x00, one more gives 0x01).

Source files
------------

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster timing (hsync/vsync/video_on, pixel coordinates,
//               line/frame start pulses) running on the pixel clock.
//               Optional frame_count output enabled by VGA_FRAME_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk_d,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam int         c_H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int         c_V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_DISP   = 10'(H_DISPLAY);
    localparam logic [9:0] c_V_DISP   = 10'(V_DISPLAY);
    localparam logic [9:0] c_HS_START = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] c_HS_END   = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_VS_START = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] c_VS_END   = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic       w_h_wrap;
    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;
    logic       w_hs_nxt;
    logic       w_vs_nxt;
    logic       w_video_nxt;
    logic       w_line_nxt;
    logic       w_frame_nxt;

    // ">=" rather than "==" so an upset counter value still wraps to 0.
    assign w_h_wrap = (pixel_x >= c_H_LAST);
    assign w_x_nxt  = w_h_wrap ? 10'd0 : pixel_x + 10'd1;
    assign w_y_nxt  = !w_h_wrap             ? pixel_y :
                      (pixel_y >= c_V_LAST) ? 10'd0   : pixel_y + 10'd1;

    // Decodes use next-count values so every output flop describes one pixel.
    assign w_hs_nxt    = (w_x_nxt >= c_HS_START) && (w_x_nxt <= c_HS_END);
    assign w_vs_nxt    = (w_y_nxt >= c_VS_START) && (w_y_nxt <= c_VS_END);
    assign w_video_nxt = (w_x_nxt < c_H_DISP) && (w_y_nxt < c_V_DISP);
    assign w_line_nxt  = (w_x_nxt == 10'd0);
    assign w_frame_nxt = w_line_nxt && (w_y_nxt == 10'd0);

    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            video_on    <= 1'b1;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            pixel_x     <= w_x_nxt;
            pixel_y     <= w_y_nxt;
            hsync       <= w_hs_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= w_vs_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on    <= w_video_nxt;
            line_start  <= w_line_nxt;
            frame_start <= w_frame_nxt;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    // Counts only frame starts reached by counting, never the reset-forced one.
    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            frame_count <= 8'd0;
        end else if (w_frame_nxt) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench for vga_sync_gen with a reduced raster,
//               both sync polarities, and randomized asynchronous resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    localparam int HD  = 8;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VD  = 4;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int HT  = HD + HFP + HS + HBP;
    localparam int VT  = VD + VFP + VS + VBP;
    localparam int FT  = HT * VT;

    logic       clk_d = 1'b0;
    logic       reset = 1'b1;
    logic       hs0, vs0, vo0, ls0, fs0;
    logic       hs1, vs1, vo1, ls1, fs1;
    logic [9:0] px0, py0, px1, py1;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] fc0, fc1;
`endif

    int checks   = 0;
    int failures = 0;
    int t        = 0;
    int cyc      = 0;
    int last_ls  = -1;
    int last_fs  = -1;

    always #5 clk_d = ~clk_d;

    vga_sync_gen #(
        .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_ACTIVE(1'b0)
    ) u_dut_lo (
        .clk_d(clk_d), .reset(reset), .hsync(hs0), .vsync(vs0),
        .video_on(vo0), .pixel_x(px0), .pixel_y(py0),
        .line_start(ls0), .frame_start(fs0)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(fc0)
`endif
    );

    vga_sync_gen #(
        .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_ACTIVE(1'b1)
    ) u_dut_hi (
        .clk_d(clk_d), .reset(reset), .hsync(hs1), .vsync(vs1),
        .video_on(vo1), .pixel_x(px1), .pixel_y(py1),
        .line_start(ls1), .frame_start(fs1)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(fc1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: pixel index t since reset maps straight to (x, y) by division.
    task automatic check_all();
        int   x, y;
        logic h_act, v_act;
        x     = t % HT;
        y     = (t / HT) % VT;
        h_act = (x >= HD + HFP) && (x < HD + HFP + HS);
        v_act = (y >= VD + VFP) && (y < VD + VFP + VS);
        chk("pixel_x",     px0, x);
        chk("pixel_y",     py0, y);
        chk("hsync_lo",    hs0, !h_act);
        chk("vsync_lo",    vs0, !v_act);
        chk("video_on",    vo0, (x < HD) && (y < VD));
        chk("line_start",  ls0, x == 0);
        chk("frame_start", fs0, (x == 0) && (y == 0));
        chk("pixel_x_hi",  px1, x);
        chk("pixel_y_hi",  py1, y);
        chk("video_on_hi", vo1, (x < HD) && (y < VD));
        chk("hsync_hi",    hs1, h_act);
        chk("vsync_hi",    vs1, v_act);
`ifdef VGA_FRAME_COUNT_EN
        chk("frame_count", fc0, (t / FT) % 256);
        chk("frame_count_hi", fc1, (t / FT) % 256);
`endif
        if (reset) begin
            last_ls = cyc;
            last_fs = cyc;
        end else begin
            if (ls0) begin
                if (last_ls >= 0) chk("line_period", cyc - last_ls, HT);
                last_ls = cyc;
            end
            if (fs0) begin
                if (last_fs >= 0) chk("frame_period", cyc - last_fs, FT);
                last_fs = cyc;
            end
        end
    endtask

    task automatic step();
        @(posedge clk_d);
        cyc++;
        if (!reset) t++;
        @(negedge clk_d);
        check_all();
    endtask

    // Asserts reset 1..3 time units after a rising edge, checks before the next edge.
    task automatic mid_cycle_reset();
        @(posedge clk_d);
        cyc++;
        t++;
        #($urandom_range(1, 3));
        reset = 1'b1;
        #1;
        t = 0;
        check_all();
        @(negedge clk_d);
        check_all();
        repeat ($urandom_range(0, 2)) step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        chk("first_edge_x", px0, 1);
        repeat (3 * FT + 5) step();

        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(20, 2 * FT)) step();
            mid_cycle_reset();
        end
        repeat (2 * FT) step();

`ifdef VGA_FRAME_COUNT_EN
        mid_cycle_reset();
        repeat (257 * FT) step();
        chk("frame_count_wrap", fc0, 8'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
